// File: rtl/memory_access_pkg.sv
// Shared types and encodings for the memory-access / writeback stage.
package memory_access_pkg;

    // Transaction FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // RV64 funct3 encodings for loads; stores reuse the low four (SB/SH/SW/SD)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Writeback data source select
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_PC   = 2'b10;
    localparam logic [1:0] WB_NONE = 2'b11;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane logic: request legality, store strobes/shift,
// load lane select with sign/zero extension.
module load_store_align
    import memory_access_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int STRB_SIZE = XLEN / 8
) (
    input  logic                 read_enable,
    input  logic                 write_enable,
    input  logic [2:0]           req_type,
    input  logic [2:0]           req_offset,
    input  logic [XLEN-1:0]      store_data,
    input  logic [2:0]           load_type,
    input  logic [2:0]           load_offset,
    input  logic [XLEN-1:0]      load_data,
    output logic                 legal,
    output logic [STRB_SIZE-1:0] wstrb,
    output logic [XLEN-1:0]      wdata,
    output logic [XLEN-1:0]      load_value
);

    logic                 funct_ok;
    logic                 align_ok;
    logic [STRB_SIZE-1:0] strb_base;
    logic [XLEN-1:0]      lane;

    // Legality: exactly one of read/write, a defined funct3, natural alignment
    always_comb begin
        funct_ok = 1'b0;
        align_ok = 1'b0;
        legal    = 1'b0;
        if (read_enable ^ write_enable) begin
            funct_ok = read_enable ? (req_type != 3'b111) : (req_type[2] == 1'b0);
            case (req_type[1:0])
                2'b00:   align_ok = 1'b1;
                2'b01:   align_ok = ~req_offset[0];
                2'b10:   align_ok = ~|req_offset[1:0];
                default: align_ok = ~|req_offset;
            endcase
            legal = funct_ok & align_ok;
        end
    end

    // Store path: size-based strobe and data moved up to the addressed byte lane
    always_comb begin
        case (req_type[1:0])
            2'b00:   strb_base = STRB_SIZE'(8'h01);
            2'b01:   strb_base = STRB_SIZE'(8'h03);
            2'b10:   strb_base = STRB_SIZE'(8'h0F);
            default: strb_base = STRB_SIZE'(8'hFF);
        endcase
        wstrb = strb_base << req_offset;
        wdata = store_data << {req_offset, 3'b000};
    end

    // Load path: bring the addressed lane to bit 0, then extend by type
    always_comb begin
        lane = load_data >> {load_offset, 3'b000};
        case (load_type)
            F3_B:    load_value = {{(XLEN-8){lane[7]}},   lane[7:0]};
            F3_H:    load_value = {{(XLEN-16){lane[15]}}, lane[15:0]};
            F3_W:    load_value = {{(XLEN-32){lane[31]}}, lane[31:0]};
            F3_BU:   load_value = {{(XLEN-8){1'b0}},      lane[7:0]};
            F3_HU:   load_value = {{(XLEN-16){1'b0}},     lane[15:0]};
            F3_WU:   load_value = {{(XLEN-32){1'b0}},     lane[31:0]};
            F3_D:    load_value = lane;
            default: load_value = lane;
        endcase
    end

endmodule

// File: rtl/memory_access_cycle.sv
// Memory-access / writeback stage: drives a req/gnt/rvalid data-memory port,
// stalls upstream while a transaction is in flight and returns a registered
// one-cycle writeback pulse to the register file.
module memory_access_cycle
    import memory_access_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter int REGISTER_SIZE = 5,
    parameter int FUNCT3_SIZE   = 3,
    parameter int STRB_SIZE     = XLEN / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ma_valid,
    input  logic                     ma_read_enable,
    input  logic                     ma_write_enable,
    input  logic [FUNCT3_SIZE-1:0]   ma_type,
    input  logic [XLEN-1:0]          ma_addr,
    input  logic [XLEN-1:0]          ma_write_data,
    input  logic [XLEN-1:0]          ma_alu_result,
    input  logic [XLEN-1:0]          ma_pc_plus4,
    input  logic                     ma_rf_write_enable,
    input  logic [REGISTER_SIZE-1:0] ma_rf_write_addr,
    input  logic [1:0]               ma_rf_write_data_sel,
    output logic                     ma_stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [XLEN-1:0]          mem_addr,
    output logic [XLEN-1:0]          mem_wdata,
    output logic [STRB_SIZE-1:0]     mem_wstrb,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [XLEN-1:0]          mem_rdata,
    output logic                     rf_writeback_enable,
    output logic [REGISTER_SIZE-1:0] rf_writeback_addr,
    output logic [XLEN-1:0]          rf_writeback_data,
    output logic                     misaligned_fault
);

    state_t                   state, state_next;
    logic                     memop, legal;
    logic                     accept, fault_set, direct_wb, load_done;
    logic [STRB_SIZE-1:0]     align_wstrb;
    logic [XLEN-1:0]          align_wdata, load_value;

    // Captured request, held stable through REQ/RESP
    logic                     req_we;
    logic [XLEN-1:0]          req_addr;
    logic [2:0]               req_offset;
    logic [2:0]               req_type;
    logic [XLEN-1:0]          req_wdata;
    logic [STRB_SIZE-1:0]     req_wstrb;
    logic                     req_rf_we;
    logic [REGISTER_SIZE-1:0] req_rd;
    logic [1:0]               req_sel;

    assign memop = ma_read_enable | ma_write_enable;

    load_store_align #(
        .XLEN      (XLEN),
        .STRB_SIZE (STRB_SIZE)
    ) u_align (
        .read_enable  (ma_read_enable),
        .write_enable (ma_write_enable),
        .req_type     (ma_type),
        .req_offset   (ma_addr[2:0]),
        .store_data   (ma_write_data),
        .load_type    (req_type),
        .load_offset  (req_offset),
        .load_data    (mem_rdata),
        .legal        (legal),
        .wstrb        (align_wstrb),
        .wdata        (align_wdata),
        .load_value   (load_value)
    );

    // Writeback data for instructions that do not touch memory
    function automatic logic [XLEN-1:0] direct_data(input logic [1:0] sel,
                                                    input logic [XLEN-1:0] alu,
                                                    input logic [XLEN-1:0] pc4);
        case (sel)
            WB_ALU:  direct_data = alu;
            WB_PC:   direct_data = pc4;
            WB_MEM:  direct_data = '0;
            default: direct_data = '0;
        endcase
    endfunction

    // FSM state register; asynchronous reset drops mem_req/ma_stall at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next state, request strobe and per-cycle event decode
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        accept     = 1'b0;
        fault_set  = 1'b0;
        direct_wb  = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                if (ma_valid) begin
                    if (!memop) begin
                        direct_wb = 1'b1;
                    end else if (legal) begin
                        accept     = 1'b1;
                        state_next = REQ;
                    end else begin
                        fault_set = 1'b1;
                    end
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) state_next = req_we ? IDLE : RESP;
            end
            RESP: begin
                if (mem_rvalid) begin
                    load_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ma_stall  = (state != IDLE) | (ma_valid & memop & legal);
    assign mem_we    = mem_req & req_we;
    assign mem_addr  = mem_req ? req_addr  : '0;
    assign mem_wdata = mem_req ? req_wdata : '0;
    assign mem_wstrb = mem_req ? req_wstrb : '0;

    // Capture an accepted request so the memory port stays stable until gnt
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_offset <= '0;
            req_type   <= '0;
            req_wdata  <= '0;
            req_wstrb  <= '0;
            req_rf_we  <= 1'b0;
            req_rd     <= '0;
            req_sel    <= '0;
        end else if (accept) begin
            req_we     <= ma_write_enable;
            req_addr   <= {ma_addr[XLEN-1:3], 3'b000};
            req_offset <= ma_addr[2:0];
            req_type   <= ma_type;
            req_wdata  <= align_wdata;
            req_wstrb  <= align_wstrb & {STRB_SIZE{ma_write_enable}};
            req_rf_we  <= ma_rf_write_enable;
            req_rd     <= ma_rf_write_addr;
            req_sel    <= ma_rf_write_data_sel;
        end
    end

    // Registered writeback pulse and fault pulse; x0 and reserved select never write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_writeback_enable <= 1'b0;
            rf_writeback_addr   <= '0;
            rf_writeback_data   <= '0;
            misaligned_fault    <= 1'b0;
        end else begin
            misaligned_fault <= fault_set;
            if (direct_wb) begin
                rf_writeback_enable <= ma_rf_write_enable & (ma_rf_write_addr != '0) &
                                       (ma_rf_write_data_sel != WB_NONE);
                rf_writeback_addr   <= ma_rf_write_addr;
                rf_writeback_data   <= direct_data(ma_rf_write_data_sel, ma_alu_result, ma_pc_plus4);
            end else if (load_done) begin
                rf_writeback_enable <= req_rf_we & (req_rd != '0) & (req_sel != WB_NONE);
                rf_writeback_addr   <= req_rd;
                rf_writeback_data   <= load_value;
            end else begin
                rf_writeback_enable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_cycle.sv
// Bench for memory_access_cycle: directed cases plus randomized transactions
// checked against an arithmetic reference model; the bench plays the memory.
module tb_memory_access_cycle;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ma_valid = 1'b0, ma_read_enable = 1'b0, ma_write_enable = 1'b0;
    logic [2:0]  ma_type = '0;
    logic [63:0] ma_addr = '0, ma_write_data = '0, ma_alu_result = '0, ma_pc_plus4 = '0;
    logic        ma_rf_write_enable = 1'b0;
    logic [4:0]  ma_rf_write_addr = '0;
    logic [1:0]  ma_rf_write_data_sel = '0;
    logic        ma_stall, mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        rf_writeback_enable;
    logic [4:0]  rf_writeback_addr;
    logic [63:0] rf_writeback_data;
    logic        misaligned_fault;

    int n_tests = 0;
    int n_fail  = 0;

    memory_access_cycle dut (
        .clk                  (clk),
        .rst                  (rst),
        .ma_valid             (ma_valid),
        .ma_read_enable       (ma_read_enable),
        .ma_write_enable      (ma_write_enable),
        .ma_type              (ma_type),
        .ma_addr              (ma_addr),
        .ma_write_data        (ma_write_data),
        .ma_alu_result        (ma_alu_result),
        .ma_pc_plus4          (ma_pc_plus4),
        .ma_rf_write_enable   (ma_rf_write_enable),
        .ma_rf_write_addr     (ma_rf_write_addr),
        .ma_rf_write_data_sel (ma_rf_write_data_sel),
        .ma_stall             (ma_stall),
        .mem_req              (mem_req),
        .mem_we               (mem_we),
        .mem_addr             (mem_addr),
        .mem_wdata            (mem_wdata),
        .mem_wstrb            (mem_wstrb),
        .mem_gnt              (mem_gnt),
        .mem_rvalid           (mem_rvalid),
        .mem_rdata            (mem_rdata),
        .rf_writeback_enable  (rf_writeback_enable),
        .rf_writeback_addr    (rf_writeback_addr),
        .rf_writeback_data    (rf_writeback_data),
        .misaligned_fault     (misaligned_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"},   64'(mem_req),             64'd0);
        check({tag, "_stall"}, 64'(ma_stall),            64'd0);
        check({tag, "_wb"},    64'(rf_writeback_enable), 64'd0);
    endtask

    // One instruction through the stage, with the bench acting as memory.
    task automatic do_op(input logic rd_en, input logic wr_en, input logic [2:0] ty,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input logic [63:0] alu, input logic [63:0] pc4,
                         input logic rfwe, input logic [4:0] rd, input logic [1:0] sel,
                         input int gd, input int rvd, input logic [63:0] rdata);
        logic        memop, lgl, e_en;
        int          size, off;
        logic [63:0] e_strb, e_wdata, e_load, mask;

        // Reference model from the access rules, in plain arithmetic
        memop   = rd_en | wr_en;
        size    = 1 << ty[1:0];
        off     = int'(addr[2:0]);
        lgl     = memop && !(rd_en && wr_en) && (rd_en ? (ty != 3'd7) : (ty < 3'd4)) &&
                  ((off % size) == 0);
        e_strb  = ((64'd1 << size) - 64'd1) << off;
        e_wdata = wd << (8 * off);
        mask    = (size == 8) ? '1 : ((64'd1 << (8 * size)) - 64'd1);
        e_load  = (rdata >> (8 * off)) & mask;
        if (ty < 3'd4 && size < 8 && e_load[8*size-1]) e_load = e_load | ~mask;
        e_en    = rfwe && (rd != 5'd0) && (sel != 2'd3);

        @(posedge clk); #1;
        ma_valid = 1'b1; ma_read_enable = rd_en; ma_write_enable = wr_en; ma_type = ty;
        ma_addr = addr; ma_write_data = wd; ma_alu_result = alu; ma_pc_plus4 = pc4;
        ma_rf_write_enable = rfwe; ma_rf_write_addr = rd; ma_rf_write_data_sel = sel;
        @(negedge clk);
        check("stall_on_issue", 64'(ma_stall), 64'(lgl));
        check("req_on_issue",   64'(mem_req),  64'd0);
        @(posedge clk); #1;
        ma_valid = 1'b0;
        ma_read_enable = 1'(($urandom() & 1)); ma_write_enable = 1'(($urandom() & 1));
        @(negedge clk);

        if (!memop) begin
            check("direct_wb_en", 64'(rf_writeback_enable), 64'(e_en));
            if (e_en) begin
                check("direct_wb_addr", 64'(rf_writeback_addr), 64'(rd));
                check("direct_wb_data", rf_writeback_data, (sel == 2'd2) ? pc4 : alu);
            end
            check("direct_no_fault", 64'(misaligned_fault), 64'd0);
            check("direct_no_stall", 64'(ma_stall), 64'd0);
            @(posedge clk); #1; @(negedge clk);
            check("direct_wb_pulse", 64'(rf_writeback_enable), 64'd0);
        end else if (!lgl) begin
            check("fault_set", 64'(misaligned_fault), 64'd1);
            check_idle_outputs("fault");
            @(posedge clk); #1; @(negedge clk);
            check("fault_pulse", 64'(misaligned_fault), 64'd0);
            check_idle_outputs("fault_after");
        end else begin
            for (int i = 0; i <= gd; i++) begin
                check("req_high",  64'(mem_req),  64'd1);
                check("req_stall", 64'(ma_stall), 64'd1);
                check("req_we",    64'(mem_we),   64'(wr_en));
                check("req_addr",  mem_addr, {addr[63:3], 3'b000});
                if (wr_en) begin
                    check("req_wstrb", 64'(mem_wstrb), e_strb);
                    check("req_wdata", mem_wdata, e_wdata);
                end
                check("req_no_wb", 64'(rf_writeback_enable), 64'd0);
                if (i == gd) begin
                    mem_gnt = 1'b1; mem_rvalid = 1'b0;
                end else begin
                    mem_rvalid = 1'(($urandom() & 1));
                end
                @(posedge clk); #1;
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
                @(negedge clk);
            end
            if (wr_en) begin
                check_idle_outputs("store_done");
            end else begin
                for (int i = 0; i <= rvd; i++) begin
                    check("resp_req",   64'(mem_req),  64'd0);
                    check("resp_stall", 64'(ma_stall), 64'd1);
                    check("resp_no_wb", 64'(rf_writeback_enable), 64'd0);
                    if (i == rvd) begin
                        mem_rvalid = 1'b1; mem_rdata = rdata;
                    end
                    @(posedge clk); #1;
                    mem_rvalid = 1'b0; mem_rdata = {$urandom(), $urandom()};
                    @(negedge clk);
                end
                check("load_wb_en", 64'(rf_writeback_enable), 64'(e_en));
                if (e_en) begin
                    check("load_wb_addr", 64'(rf_writeback_addr), 64'(rd));
                    check("load_wb_data", rf_writeback_data, e_load);
                end
                check("load_no_stall", 64'(ma_stall), 64'd0);
                @(posedge clk); #1; @(negedge clk);
                check("load_wb_pulse", 64'(rf_writeback_enable), 64'd0);
            end
        end
    endtask

    initial begin
        logic        rd_en, wr_en, rfwe;
        logic [2:0]  ty, amask;
        logic [63:0] a;
        logic [1:0]  sel;
        int          kind, s;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_we",    64'(mem_we),            64'd0);
        check("reset_addr",  mem_addr,               64'd0);
        check("reset_wstrb", 64'(mem_wstrb),         64'd0);
        check("reset_wdata", mem_wdata,              64'd0);
        check("reset_wbaddr",64'(rf_writeback_addr), 64'd0);
        check("reset_wbdata",rf_writeback_data,      64'd0);
        check("reset_fault", 64'(misaligned_fault),  64'd0);
        @(posedge clk); #1; rst = 1'b1;

        // Directed cases
        do_op(1, 0, 3'b010, 64'h1004, 64'd0, 64'd0, 64'd0, 1, 5'd5, 2'b01, 0, 0, 64'h80000001_12345678);
        do_op(1, 0, 3'b100, 64'h1007, 64'd0, 64'd0, 64'd0, 1, 5'd6, 2'b01, 1, 2, 64'hF0_00000000000000);
        do_op(1, 0, 3'b000, 64'h1007, 64'd0, 64'd0, 64'd0, 1, 5'd7, 2'b01, 0, 1, 64'hF0_11223344556677);
        do_op(0, 1, 3'b001, 64'h2002, 64'hABCD, 64'd0, 64'd0, 0, 5'd0, 2'b00, 0, 0, 64'd0);
        do_op(0, 1, 3'b010, 64'h2004, 64'hDEADBEEF, 64'd0, 64'd0, 0, 5'd0, 2'b00, 3, 0, 64'd0);
        do_op(1, 0, 3'b011, 64'h3004, 64'd0, 64'd0, 64'd0, 1, 5'd8, 2'b01, 0, 0, 64'd0);
        do_op(0, 0, 3'b000, 64'h0, 64'd0, 64'h55, 64'h104, 1, 5'd0, 2'b00, 0, 0, 64'd0);
        do_op(0, 0, 3'b000, 64'h0, 64'd0, 64'h55, 64'h104, 1, 5'd9, 2'b10, 0, 0, 64'd0);
        do_op(1, 0, 3'b111, 64'h4000, 64'd0, 64'd0, 64'd0, 1, 5'd3, 2'b01, 0, 0, 64'd0);
        do_op(1, 1, 3'b000, 64'h4000, 64'd0, 64'd0, 64'd0, 1, 5'd3, 2'b01, 0, 0, 64'd0);

        // Reset asserted while a load waits in RESP
        @(posedge clk); #1;
        ma_valid = 1'b1; ma_read_enable = 1'b1; ma_write_enable = 1'b0; ma_type = 3'b011;
        ma_addr = 64'h5000; ma_rf_write_enable = 1'b1; ma_rf_write_addr = 5'd4;
        ma_rf_write_data_sel = 2'b01;
        @(posedge clk); #1; ma_valid = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1; mem_gnt = 1'b0;
        @(negedge clk);
        check("rst_mid_stall_before", 64'(ma_stall), 64'd1);
        #1 rst = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        @(posedge clk); #1; rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h1234;
        @(posedge clk); #1; mem_rvalid = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_late_rvalid");

        // Randomized transactions
        for (int n = 0; n < 200; n++) begin
            kind  = $urandom_range(0, 9);
            rd_en = (kind <= 3) || (kind == 9);
            wr_en = (kind >= 4 && kind <= 6) || (kind == 9);
            ty    = 3'($urandom_range(0, 7));
            a     = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) != 0) begin
                amask  = 3'((1 << ty[1:0]) - 1);
                a[2:0] = a[2:0] & ~amask;
            end
            rfwe = ($urandom_range(0, 5) != 0);
            if (kind >= 7 && kind <= 8) begin
                s   = $urandom_range(0, 2);
                sel = (s == 0) ? 2'b00 : ((s == 1) ? 2'b10 : 2'b11);
            end else begin
                sel = ($urandom_range(0, 5) == 0) ? 2'b11 : 2'b01;
            end
            do_op(rd_en, wr_en, ty, a, {$urandom(), $urandom()},
                  {$urandom(), $urandom()}, {$urandom(), $urandom()},
                  rfwe, 5'($urandom_range(0, 31)), sel,
                  $urandom_range(0, 3), $urandom_range(0, 3), {$urandom(), $urandom()});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
